ex_divctrl: RTL and testbench

- Iterative integer divide sequencer for the EX stage of the RV64 pipeline.
- Accepts DIV/DIVU/REM/REMU and their W variants from EX and runs a radix-2 restoring shift-subtract loop: 32 iterations for word ops, 64 for doubleword ops.
- Resolves the RISC-V divide-by-zero and signed-overflow cases without iterating.
- Applies word-result sign extension: bit 31 replicated into [63:32].
- Handshakes with the pipeline stall/flush logic.

---
 rtl/ex_divctrl.sv | 140 ++++++++++++++
 tb/tb_ex_divctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_divctrl.sv
// Iterative radix-2 restoring divider for the RV64 EX stage (DIV/DIVU/REM/REMU and W forms).
// Divide-by-zero and signed overflow resolve in one cycle; all other ops iterate 32 or 64 times.
module ex_divctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_divctrl_start_i,
    input  logic            ex_divctrl_signed_i,
    input  logic            ex_divctrl_rem_i,
    input  logic            ex_divctrl_word_i,
    input  logic [XLEN-1:0] ex_divctrl_dividend_i,
    input  logic [XLEN-1:0] ex_divctrl_divisor_i,
    input  logic            ex_divctrl_ack_i,
    input  logic            ex_divctrl_flush_i,
    output logic            ex_divctrl_ready_o,
    output logic            ex_divctrl_busy_o,
    output logic            ex_divctrl_valid_o,
    output logic [XLEN-1:0] ex_divctrl_res_data_o
);

    localparam int WLEN = XLEN / 2;
    localparam int CW   = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] N_WORD  = CW'(WLEN);
    localparam logic [CW-1:0] N_DWORD = CW'(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, div_q, res_q;
    logic            neg_quo_q, neg_rem_q, rem_sel_q, word_q;

    // W results always carry bit 31 into the upper half, unsigned ops included.
    function automatic logic [XLEN-1:0] fix_width(input logic [XLEN-1:0] v, input logic w);
        return w ? {{WLEN{v[WLEN-1]}}, v[WLEN-1:0]} : v;
    endfunction

    // Operand conditioning at capture time.
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, most_neg, spec_res;
    logic            a_neg, b_neg, div_zero, ovf, capture;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        a_ext = ex_divctrl_dividend_i;
        b_ext = ex_divctrl_divisor_i;
        most_neg = {1'b1, {(XLEN-1){1'b0}}};
        if (ex_divctrl_word_i) begin
            a_ext = {{WLEN{ex_divctrl_signed_i & ex_divctrl_dividend_i[WLEN-1]}},
                     ex_divctrl_dividend_i[WLEN-1:0]};
            b_ext = {{WLEN{ex_divctrl_signed_i & ex_divctrl_divisor_i[WLEN-1]}},
                     ex_divctrl_divisor_i[WLEN-1:0]};
            most_neg = {{(WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};
        end
        a_neg    = ex_divctrl_signed_i & a_ext[XLEN-1];
        b_neg    = ex_divctrl_signed_i & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        ovf      = ex_divctrl_signed_i && (a_ext == most_neg) && (b_ext == '1);
        if (div_zero)
            spec_res = ex_divctrl_rem_i ? a_ext : '1;
        else
            spec_res = ex_divctrl_rem_i ? '0 : a_ext;
        spec_res = fix_width(spec_res, ex_divctrl_word_i);
    end

    // One restoring step; the shifted remainder needs XLEN+1 bits for full-width divisors.
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] rem_sub, rem_nx, quo_nx, calc_res;
    logic            ge;

    always_comb begin
        rem_sh  = {rem_q, quo_q[XLEN-1]};
        ge      = (rem_sh >= {1'b0, div_q});
        rem_sub = rem_sh[XLEN-1:0] - div_q;
        rem_nx  = ge ? rem_sub : rem_sh[XLEN-1:0];
        quo_nx  = {quo_q[XLEN-2:0], ge};
        if (rem_sel_q)
            calc_res = neg_rem_q ? -rem_nx : rem_nx;
        else
            calc_res = neg_quo_q ? -quo_nx : quo_nx;
        calc_res = fix_width(calc_res, word_q);
    end

    assign ex_divctrl_ready_o    = (state_q == IDLE) | ((state_q == DONE) & ex_divctrl_ack_i);
    assign ex_divctrl_busy_o     = (state_q == CALC) | ((state_q == DONE) & ~ex_divctrl_ack_i);
    assign ex_divctrl_valid_o    = (state_q == DONE);
    assign ex_divctrl_res_data_o = res_q;
    assign capture               = ex_divctrl_start_i & ex_divctrl_ready_o;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            res_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            word_q    <= 1'b0;
        end else if (ex_divctrl_flush_i) begin
            state_q <= IDLE;
        end else if (capture) begin
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            rem_sel_q <= ex_divctrl_rem_i;
            word_q    <= ex_divctrl_word_i;
            if (div_zero || ovf) begin
                state_q <= DONE;
                res_q   <= spec_res;
            end else begin
                state_q <= CALC;
                cnt_q   <= ex_divctrl_word_i ? N_WORD : N_DWORD;
                rem_q   <= '0;
                // Word dividends sit in the upper half so 32 shifts consume them fully.
                quo_q   <= ex_divctrl_word_i ? (a_mag << WLEN) : a_mag;
                div_q   <= b_mag;
            end
        end else begin
            case (state_q)
                CALC: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                        res_q   <= calc_res;
                    end
                end
                DONE: if (ex_divctrl_ack_i) state_q <= IDLE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_divctrl.sv
// Directed self-checking bench for ex_divctrl: vector table plus flush, hold,
// back-to-back and mid-operation reset sequences.
module tb_ex_divctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, signed_i, rem_i, word_i, ack_i, flush_i;
    logic [63:0] dividend_i, divisor_i;
    logic        ready_o, busy_o, valid_o;
    logic [63:0] res_data_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_divctrl #(.XLEN(64)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .ex_divctrl_start_i    (start_i),
        .ex_divctrl_signed_i   (signed_i),
        .ex_divctrl_rem_i      (rem_i),
        .ex_divctrl_word_i     (word_i),
        .ex_divctrl_dividend_i (dividend_i),
        .ex_divctrl_divisor_i  (divisor_i),
        .ex_divctrl_ack_i      (ack_i),
        .ex_divctrl_flush_i    (flush_i),
        .ex_divctrl_ready_o    (ready_o),
        .ex_divctrl_busy_o     (busy_o),
        .ex_divctrl_valid_o    (valid_o),
        .ex_divctrl_res_data_o (res_data_o)
    );

    typedef struct {
        string       name;
        logic        sgn;
        logic        rem;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic s, input logic r, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
        signed_i   = s;
        rem_i      = r;
        word_i     = w;
        dividend_i = a;
        divisor_i  = b;
    endtask

    // Drives start for one edge; returns one step after the capture edge (cycle T+1).
    task automatic start_op(input logic s, input logic r, input logic w,
                            input logic [63:0] a, input logic [63:0] b);
        set_op(s, r, w, a, b);
        start_i = 1'b1;
        #1;
        check("ready_before_start", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Latency is counted from the capture edge; bounded so a stuck DUT still ends.
    task automatic wait_valid(output int lat);
        int cyc = 0;
        while (!valid_o && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        lat = cyc + 1;
    endtask

    task automatic ack_op();
        ack_i = 1'b1;
        @(posedge clk);
        #1;
        ack_i = 1'b0;
        check("idle_after_ack", {61'd0, valid_o, busy_o, ready_o}, 64'b001);
    endtask

    int  lat;
    logic seen;

    initial begin
        vecs[0]  = '{"div_m20_3",    1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
                     64'hFFFF_FFFF_FFFF_FFFA, 65};
        vecs[1]  = '{"rem_m20_3",    1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
                     64'hFFFF_FFFF_FFFF_FFFE, 65};
        vecs[2]  = '{"divuw_fffe_1", 1'b0, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1,
                     64'hFFFF_FFFF_FFFF_FFFE, 33};
        vecs[3]  = '{"remuw_7_3",    1'b0, 1'b1, 1'b1, 64'h0000_0001_0000_0007, 64'd3,
                     64'h0000_0000_0000_0001, 33};
        vecs[4]  = '{"divu_7_0",     1'b0, 1'b0, 1'b0, 64'd7, 64'd0,
                     64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[5]  = '{"remw_x_0",     1'b1, 1'b1, 1'b1, 64'h0000_0001_8000_0005, 64'd0,
                     64'hFFFF_FFFF_8000_0005, 1};
        vecs[6]  = '{"div_ovf",      1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 1};
        vecs[7]  = '{"rem_ovf",      1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h0, 1};
        vecs[8]  = '{"divw_ovf",     1'b1, 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                     64'hFFFF_FFFF_8000_0000, 1};
        vecs[9]  = '{"divu_100_7",   1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 65};
        vecs[10] = '{"remu_big",     1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
                     64'h7FFF_FFFF_FFFF_FFFE, 65};
        vecs[11] = '{"remu_ffff_16", 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 65};
        vecs[12] = '{"divw_m7_2",    1'b1, 1'b0, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
                     64'hFFFF_FFFF_FFFF_FFFD, 33};

        rst = 1'b1;
        start_i = 1'b0;
        ack_i = 1'b0;
        flush_i = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_flags", {61'd0, valid_o, busy_o, ready_o}, 64'b001);
        check("reset_data", res_data_o, 64'd0);

        for (int i = 0; i < 13; i++) begin
            start_op(vecs[i].sgn, vecs[i].rem, vecs[i].word, vecs[i].a, vecs[i].b);
            wait_valid(lat);
            check({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
            check({vecs[i].name, "_res"}, res_data_o, vecs[i].exp);
            ack_op();
        end

        // Flush in the 10th CALC cycle of a doubleword DIVU.
        start_op(1'b0, 1'b0, 1'b0, 64'd1000, 64'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_flags", {61'd0, valid_o, busy_o, ready_o}, 64'b001);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            seen = seen | valid_o;
        end
        check("flush_no_valid", 64'(seen), 64'd0);
        start_op(1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
        wait_valid(lat);
        check("post_flush_lat", 64'(lat), 64'd65);
        check("post_flush_res", res_data_o, 64'd14);
        ack_op();

        // Hold with ack low (start attempts must be ignored), then back-to-back DIVW 9/2.
        start_op(1'b0, 1'b0, 1'b0, 64'd50, 64'd5);
        wait_valid(lat);
        check("hold_lat", 64'(lat), 64'd65);
        for (int k = 0; k < 3; k++) begin
            set_op(1'b0, 1'b0, 1'b0, 64'd1, 64'd1);
            start_i = 1'b1;
            @(posedge clk);
            #1;
            check("hold_flags", {61'd0, valid_o, busy_o, ready_o}, 64'b110);
            check("hold_data", res_data_o, 64'd10);
        end
        set_op(1'b1, 1'b0, 1'b1, 64'd9, 64'd2);
        ack_i = 1'b1;
        #1;
        check("b2b_ready", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        ack_i = 1'b0;
        check("b2b_busy", {62'd0, valid_o, busy_o}, 64'b01);
        wait_valid(lat);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_res", res_data_o, 64'd4);
        ack_op();

        // Reset mid-CALC.
        start_op(1'b0, 1'b0, 1'b0, 64'd1000, 64'd3);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_flags", {61'd0, valid_o, busy_o, ready_o}, 64'b001);
        check("midrst_data", res_data_o, 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            seen = seen | valid_o;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
